// File: rtl/komut_sequencer.sv
// Purpose: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer that owns pc, the instruction register and rf write enable.
// Latency: 4 cycles per instruction when imem_ack arrives in the first FETCH cycle, plus 1 cycle for each extra FETCH wait cycle.
// Backpressure: imem_req and imem_addr are held until imem_ack; no ack within TIMEOUT FETCH cycles sets sticky hata and halts.
module komut_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] komut,
    input  logic        hata_d,
    input  logic        hata_e,
    input  logic [31:0] alu_sonuc,
    input  logic [31:0] imm,
    output logic [31:0] pc,
    output logic        ex_en,
    output logic        rf_we,
    output logic        halted,
    output logic        hata,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OP_R       = 7'b0000001;
    localparam logic [6:0] OP_I       = 7'b0000011;
    localparam logic [6:0] OP_U       = 7'b0000111;
    localparam logic [6:0] OP_B       = 7'b0001111;
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] komut_q, komut_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] retired_q, retired_d;
    logic        sticky_hata_q, sticky_hata_d;
    logic        taken_q, taken_d;
    logic        writes_rf;

    // Only the branch condition bit of the ALU result matters to the sequencer.
    logic unused_alu_bits;
    assign unused_alu_bits = ^alu_sonuc[31:1];

    // Opcodes that produce a register result; branches and anything else never write.
    assign writes_rf = (komut_q[6:0] == OP_R) || (komut_q[6:0] == OP_I) || (komut_q[6:0] == OP_U);

    // Next-state and datapath-register updates for each sequencer step.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        komut_d       = komut_q;
        wait_d        = wait_q;
        retired_d     = retired_q;
        sticky_hata_d = sticky_hata_q;
        taken_d       = taken_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    wait_d  = 8'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // An ack on the cycle the counter would reach TIMEOUT still wins.
                if (imem_ack) begin
                    komut_d = imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q + 8'd1 == TIMEOUT_C) begin
                        sticky_hata_d = 1'b1;
                        state_d       = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                if (hata_d) begin
                    sticky_hata_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (hata_e) begin
                    sticky_hata_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    taken_d = (komut_q[6:0] == OP_B) && alu_sonuc[0];
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                pc_d      = taken_q ? (pc_q + imm) : (pc_q + 32'd4);
                retired_d = retired_q + 32'd1;
                wait_d    = 8'd0;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            komut_q       <= 32'd0;
            wait_q        <= 8'd0;
            retired_q     <= 32'd0;
            sticky_hata_q <= 1'b0;
            taken_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            komut_q       <= komut_d;
            wait_q        <= wait_d;
            retired_q     <= retired_d;
            sticky_hata_q <= sticky_hata_d;
            taken_q       <= taken_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign ex_en     = (state_q == S_EXECUTE);
    assign rf_we     = (state_q == S_WRITEBACK) && writes_rf;
    assign halted    = (state_q == S_HALT);
    assign hata      = sticky_hata_q;
    assign komut     = komut_q;
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_komut_sequencer.sv
// Purpose: randomized self-checking bench for komut_sequencer against an instruction-level model of pc/retired/rf_we.
// Latency: expects FETCH(1+wait), DECODE, EXECUTE, WRITEBACK per instruction.
// Backpressure: bench acts as instruction memory and chooses ack delay per fetch.
module tb_komut_sequencer;

    localparam int TO = 4;
    localparam logic [6:0] OP_R = 7'h01;
    localparam logic [6:0] OP_I = 7'h03;
    localparam logic [6:0] OP_U = 7'h07;
    localparam logic [6:0] OP_B = 7'h0F;

    logic        clk = 1'b0;
    logic        reset, start, imem_ack, hata_d, hata_e;
    logic [31:0] imem_rdata, alu_sonuc, imm;
    logic        imem_req, ex_en, rf_we, halted, hata;
    logic [31:0] imem_addr, komut, pc, retired;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc, m_ret;

    komut_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .komut(komut), .hata_d(hata_d), .hata_e(hata_e), .alu_sonuc(alu_sonuc), .imm(imm),
        .pc(pc), .ex_en(ex_en), .rf_we(rf_we), .halted(halted), .hata(hata), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic logic model_writes(input logic [31:0] w);
        return (w[6:0] == OP_R) || (w[6:0] == OP_I) || (w[6:0] == OP_U);
    endfunction

    function automatic logic [31:0] mk_word(input logic [6:0] op);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = op;
        return w;
    endfunction

    task automatic clear_inputs;
        start = 1'b0; imem_ack = 1'b0; hata_d = 1'b0; hata_e = 1'b0;
        imem_rdata = 32'd0; alu_sonuc = 32'd0; imm = 32'd0;
    endtask

    task automatic do_reset_start;
        clear_inputs();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        m_pc = 32'd0; m_ret = 32'd0;
    endtask

    // One instruction from its first FETCH cycle; leaves the bench at the next FETCH, in HALT, or in reset.
    task automatic run_instr(input logic [31:0] word, input int nwait, input logic [31:0] immv,
                             input logic [31:0] aluv, input bit ed, input bit ee, input bit abort,
                             output bit halted_o);
        logic taken;
        halted_o = 1'b0;
        for (int j = 0; j <= nwait; j++) begin
            n_cmp++;
            if ({imem_req, ex_en, rf_we, halted, hata} !== 5'b10000 || imem_addr !== m_pc) begin
                n_bad++;
                $display("FAIL fetch_hold: req/ex/we/halt/hata=%b addr=%h, want 10000 addr=%h",
                         {imem_req, ex_en, rf_we, halted, hata}, imem_addr, m_pc);
            end
            imem_ack   = (j == nwait);
            imem_rdata = (j == nwait) ? word : $urandom;
            hata_d     = 1'($urandom);
            hata_e     = 1'($urandom);
            @(negedge clk);
        end
        // DECODE
        imem_ack = 1'($urandom); hata_e = 1'($urandom); imem_rdata = $urandom;
        n_cmp++;
        if (komut !== word || {imem_req, ex_en, rf_we, halted} !== 4'b0000) begin
            n_bad++;
            $display("FAIL decode: komut=%h strobes=%b, want komut=%h strobes=0000",
                     komut, {imem_req, ex_en, rf_we, halted}, word);
        end
        hata_d = ed;
        @(negedge clk);
        hata_d = 1'b0; hata_e = 1'b0; imem_ack = 1'b0;
        if (ed) begin
            n_cmp++;
            if ({imem_req, ex_en, rf_we, halted, hata} !== 5'b00011 || pc !== m_pc || retired !== m_ret) begin
                n_bad++;
                $display("FAIL halt_decode: strobes/halt/hata=%b pc=%h ret=%0d, want 00011 pc=%h ret=%0d",
                         {imem_req, ex_en, rf_we, halted, hata}, pc, retired, m_pc, m_ret);
            end
            halted_o = 1'b1;
            return;
        end
        // EXECUTE
        n_cmp++;
        if ({imem_req, ex_en, rf_we, halted} !== 4'b0100) begin
            n_bad++;
            $display("FAIL execute: strobes=%b, want 0100", {imem_req, ex_en, rf_we, halted});
        end
        hata_e = ee; alu_sonuc = aluv; imm = immv;
        imem_ack = 1'($urandom); hata_d = 1'($urandom);
        @(negedge clk);
        hata_e = 1'b0; hata_d = 1'b0; imem_ack = 1'b0;
        if (ee) begin
            n_cmp++;
            if ({imem_req, ex_en, rf_we, halted, hata} !== 5'b00011 || pc !== m_pc || retired !== m_ret) begin
                n_bad++;
                $display("FAIL halt_execute: strobes/halt/hata=%b pc=%h ret=%0d, want 00011 pc=%h ret=%0d",
                         {imem_req, ex_en, rf_we, halted, hata}, pc, retired, m_pc, m_ret);
            end
            halted_o = 1'b1;
            return;
        end
        // WRITEBACK: taken decision is already latched, so alu_sonuc may change freely
        n_cmp++;
        if ({imem_req, ex_en, rf_we, halted, hata} !== {2'b00, model_writes(word), 2'b00} ||
            pc !== m_pc || retired !== m_ret) begin
            n_bad++;
            $display("FAIL writeback: strobes/halt/hata=%b pc=%h ret=%0d, want %b pc=%h ret=%0d",
                     {imem_req, ex_en, rf_we, halted, hata}, pc, retired,
                     {2'b00, model_writes(word), 2'b00}, m_pc, m_ret);
        end
        alu_sonuc = $urandom; hata_d = 1'($urandom); hata_e = 1'($urandom); imem_ack = 1'($urandom);
        if (abort) begin
            reset = 1'b0;
            #1;
            n_cmp++;
            if ({imem_req, ex_en, rf_we, halted, hata} !== 5'b00000 || pc !== 32'd0 ||
                imem_addr !== 32'd0 || komut !== 32'd0 || retired !== 32'd0) begin
                n_bad++;
                $display("FAIL async_reset: strobes/halt/hata=%b pc=%h komut=%h ret=%0d, want all zero",
                         {imem_req, ex_en, rf_we, halted, hata}, pc, komut, retired);
            end
            halted_o = 1'b1;
            return;
        end
        @(negedge clk);
        clear_inputs();
        taken = (word[6:0] == OP_B) && aluv[0];
        m_pc  = taken ? m_pc + immv : m_pc + 32'd4;
        m_ret = m_ret + 32'd1;
        n_cmp++;
        if ({imem_req, ex_en, rf_we, halted} !== 4'b1000 || imem_addr !== m_pc || retired !== m_ret) begin
            n_bad++;
            $display("FAIL next_fetch: strobes=%b addr=%h ret=%0d, want 1000 addr=%h ret=%0d",
                     {imem_req, ex_en, rf_we, halted}, imem_addr, retired, m_pc, m_ret);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b0; start = 1'b1;
        #3;
        n_cmp++;
        if ({imem_req, ex_en, rf_we, halted, hata} !== 5'b00000 || pc !== 32'd0 || komut !== 32'd0 || retired !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_values: strobes/halt/hata=%b pc=%h komut=%h ret=%0d, want all zero",
                     {imem_req, ex_en, rf_we, halted, hata}, pc, komut, retired);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: imem_req=%b, want 0", imem_req);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_bad++;
            $display("FAIL idle_start: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        bit h;
        do_reset_start();
        for (int i = 0; i < 4; i++) run_instr(mk_word(OP_R), 0, $urandom, $urandom, 0, 0, 0, h);
        n_cmp++;
        if (pc !== 32'd16 || retired !== 32'd4) begin
            n_bad++;
            $display("FAIL back_to_back: pc=%h ret=%0d, want 00000010 4", pc, retired);
        end
    endtask

    task automatic test_delayed_ack;
        bit h;
        do_reset_start();
        run_instr(mk_word(OP_I), 3, 32'd0, 32'd0, 0, 0, 0, h);
        run_instr(mk_word(OP_U), TO - 1, 32'd0, 32'd0, 0, 0, 0, h);
    endtask

    task automatic test_branch;
        bit h;
        for (int t = 1; t >= 0; t--) begin
            do_reset_start();
            for (int i = 0; i < 8; i++) run_instr(mk_word(OP_R), 0, 32'd0, 32'd0, 0, 0, 0, h);
            run_instr(mk_word(OP_B), 0, 32'h40, {31'($urandom), 1'(t)}, 0, 0, 0, h);
            n_cmp++;
            if (imem_addr !== (t ? 32'h60 : 32'h24)) begin
                n_bad++;
                $display("FAIL branch_%0d: addr=%h, want %h", t, imem_addr, t ? 32'h60 : 32'h24);
            end
        end
        do_reset_start();
        run_instr(mk_word(OP_B), 1, 32'hFFFF_FFFC, 32'd1, 0, 0, 0, h);
        run_instr(mk_word(OP_B), 2, 32'd8, 32'd3, 0, 0, 0, h);
        n_cmp++;
        if (pc !== 32'h0000_0004) begin
            n_bad++;
            $display("FAIL branch_wrap: pc=%h, want 00000004", pc);
        end
    endtask

    task automatic test_errors;
        bit h;
        for (int k = 0; k < 2; k++) begin
            do_reset_start();
            run_instr(mk_word(OP_R), 1, 32'd0, 32'd0, 0, 0, 0, h);
            run_instr(mk_word(OP_I), 0, 32'd0, 32'd0, 0, 0, 0, h);
            run_instr(mk_word(OP_R), 0, 32'd0, 32'd0, k == 0, k == 1, 0, h);
            for (int c = 0; c < 6; c++) begin
                start = 1'($urandom); imem_ack = 1'($urandom); hata_d = 1'($urandom); hata_e = 1'($urandom);
                @(negedge clk);
            end
            clear_inputs();
            n_cmp++;
            if ({imem_req, ex_en, rf_we, halted, hata} !== 5'b00011 || pc !== 32'd8 || retired !== 32'd2) begin
                n_bad++;
                $display("FAIL halt_sticky_%0d: strobes/halt/hata=%b pc=%h ret=%0d, want 00011 00000008 2",
                         k, {imem_req, ex_en, rf_we, halted, hata}, pc, retired);
            end
        end
    endtask

    task automatic test_timeout;
        bit h;
        do_reset_start();
        for (int c = 1; c <= TO; c++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (c < TO) begin
                if ({imem_req, halted, hata} !== 3'b100) begin
                    n_bad++;
                    $display("FAIL timeout_wait_%0d: req/halt/hata=%b, want 100", c, {imem_req, halted, hata});
                end
            end else if ({imem_req, halted, hata} !== 3'b011 || pc !== 32'd0) begin
                n_bad++;
                $display("FAIL timeout_halt: req/halt/hata=%b pc=%h, want 011 00000000", {imem_req, halted, hata}, pc);
            end
        end
        do_reset_start();
        run_instr(mk_word(OP_U), 2, 32'd0, 32'd0, 0, 0, 0, h);
        run_instr(mk_word(OP_R), 1, 32'd0, 32'd0, 0, 0, 1, h);
    endtask

    task automatic test_random;
        bit h;
        logic [6:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_U; ops[3] = OP_B; ops[4] = 7'h13;
        do_reset_start();
        for (int i = 0; i < 60; i++) begin
            run_instr(mk_word(ops[$urandom_range(0, 4)]), $urandom_range(0, TO - 1), $urandom, $urandom,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, 0, h);
            if (h) do_reset_start();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_delayed_ack();
        test_branch();
        test_errors();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
